ema_filter_mc: RTL and testbench

Multi-channel, time-multiplexed exponential moving-average filter. It is the parametrised successor to the single-channel EMA stage in the AGC power-estimation path. One pipelined multiply-accumulate is shared across NCH channels, and per-channel state lives in a register array. Any channel may be presented on any cycle, including the same channel back-to-back. The block adds coefficient clamping, per-channel priming, a rounded/saturated sample output, and a synchronous active-low reset, none of which the previous generation had.

---
 rtl/ema_filter_mc_if.sv | 31 +++
 rtl/ema_filter_mc.sv | 130 +++++++++++++
 tb/tb_ema_filter_mc.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/ema_filter_mc_if.sv
// Sample/result bundle of ema_filter_mc. The master drives the samples and the slave
// (the filter) returns the results.
interface ema_filter_mc_if #(
   parameter int NCH    = 4,
   parameter int CHW    = (NCH > 1) ? $clog2(NCH) : 1,
   parameter int DWIDTH = 27,
   parameter int BWIDTH = 15,
   parameter int CSHIFT = 14,
   parameter int SWIDTH = DWIDTH + CSHIFT + 1
);
   logic                     in_valid;
   logic [CHW-1:0]           in_chan;
   logic [DWIDTH-1:0]        in_data;
   logic [BWIDTH-1:0]        in_coeff;
   logic                     in_prime;

   logic                     out_valid;
   logic [CHW-1:0]           out_chan;
   logic signed [SWIDTH-1:0] out_state;
   logic [DWIDTH-1:0]        out_data;

   modport master (
      output in_valid, in_chan, in_data, in_coeff, in_prime,
      input  out_valid, out_chan, out_state, out_data
   );

   modport slave (
      input  in_valid, in_chan, in_data, in_coeff, in_prime,
      output out_valid, out_chan, out_state, out_data
   );
endinterface

// File: rtl/ema_filter_mc.sv
// Multi-channel EMA filter: one 3-stage multiply-accumulate shared by NCH channels.
// Same-channel samples in flight are forwarded into S1, so there are no stalls.
module ema_filter_mc #(
   parameter int NCH    = 4,
   parameter int CHW    = (NCH > 1) ? $clog2(NCH) : 1,
   parameter int DWIDTH = 27,
   parameter int BWIDTH = 15,
   parameter int CSHIFT = 14,
   parameter int SWIDTH = DWIDTH + CSHIFT + 1
) (
   input logic            clk,
   input logic            rst_n,
   ema_filter_mc_if.slave bus
);
   localparam logic [BWIDTH-1:0] A_ONE = BWIDTH'(1 << CSHIFT);

   typedef struct packed {
      logic              valid;
      logic [CHW-1:0]    chan;
      logic [DWIDTH-1:0] x;
      logic [BWIDTH-1:0] a;
      logic              prime;
   } slot_t;

   slot_t                    s1_d, s1_q, s2_q;
   logic signed [SWIDTH-1:0] st_q [NCH];
   logic signed [SWIDTH-1:0] s1_st, s2_st_q, s2_new;
   logic signed [DWIDTH:0]   s2_diff;
   logic signed [SWIDTH-1:0] s2_prod;
   logic                     s3_valid_q, s3_prime_q;
   logic [CHW-1:0]           s3_chan_q;
   logic [DWIDTH-1:0]        s3_x_q;
   logic signed [SWIDTH-1:0] s3_st_q, s3_prod_q, s3_new;
   logic [DWIDTH+1:0]        rnd;
   logic [DWIDTH-1:0]        sat_data;

   logic                     out_valid_q;
   logic [CHW-1:0]           out_chan_q;
   logic signed [SWIDTH-1:0] out_state_q;
   logic [DWIDTH-1:0]        out_data_q;

   function automatic logic signed [SWIDTH-1:0] next_state(
      input logic signed [SWIDTH-1:0] st,
      input logic signed [SWIDTH-1:0] prod,
      input logic                     prime,
      input logic [DWIDTH-1:0]        x
   );
      return prime ? {1'b0, x, {CSHIFT{1'b0}}} : st + prod;
   endfunction

   // NOTE: every variable driven in always_comb gets a value on every path (defaults
   // first), otherwise synthesis infers a latch.
   always_comb begin
      s1_d       = '0;
      s1_d.valid = bus.in_valid && (int'(bus.in_chan) < NCH);
      if (s1_d.valid) begin
         s1_d.chan  = bus.in_chan;
         s1_d.x     = bus.in_data;
         s1_d.a     = (bus.in_coeff > A_ONE) ? A_ONE : bus.in_coeff;
         s1_d.prime = bus.in_prime;
      end
   end

   // The youngest in-flight result for the channel wins: S2 over S3 over the array.
   always_comb begin
      s1_st = st_q[s1_q.chan];
      if (s3_valid_q && (s3_chan_q == s1_q.chan)) s1_st = s3_new;
      if (s2_q.valid && (s2_q.chan == s1_q.chan)) s1_st = s2_new;
   end

   // a <= 2^CSHIFT and |diff| < 2^DWIDTH, so the product is exact at SWIDTH bits.
   assign s2_diff = $signed({1'b0, s2_q.x}) - $signed(s2_st_q[SWIDTH-1:CSHIFT]);
   assign s2_prod = SWIDTH'(s2_diff) * SWIDTH'($signed({1'b0, s2_q.a}));
   assign s2_new  = next_state(s2_st_q, s2_prod, s2_q.prime, s2_q.x);
   assign s3_new  = next_state(s3_st_q, s3_prod_q, s3_prime_q, s3_x_q);

   // floor(st / 2^CSHIFT) plus the half bit gives round-half-up.
   assign rnd = {s3_new[SWIDTH-1], s3_new[SWIDTH-1:CSHIFT]} + (DWIDTH+2)'(s3_new[CSHIFT-1]);

   always_comb begin
      sat_data = rnd[DWIDTH-1:0];
      if (rnd[DWIDTH+1])   sat_data = '0;
      else if (rnd[DWIDTH]) sat_data = '1;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every stage samples
   // the values from before the edge regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_q        <= '0;
         s2_q        <= '0;
         s2_st_q     <= '0;
         s3_valid_q  <= 1'b0;
         s3_chan_q   <= '0;
         s3_prime_q  <= 1'b0;
         s3_x_q      <= '0;
         s3_st_q     <= '0;
         s3_prod_q   <= '0;
         // NOTE: the state array is plain flops and must start at zero, so it is reset
         // element by element; it cannot be mapped to a RAM macro.
         for (int c = 0; c < NCH; c++) st_q[c] <= '0;
         out_valid_q <= 1'b0;
         out_chan_q  <= '0;
         out_state_q <= '0;
         out_data_q  <= '0;
      end else begin
         s1_q        <= s1_d;
         s2_q        <= s1_q;
         s2_st_q     <= s1_st;
         s3_valid_q  <= s2_q.valid;
         s3_chan_q   <= s2_q.chan;
         s3_prime_q  <= s2_q.prime;
         s3_x_q      <= s2_q.x;
         s3_st_q     <= s2_st_q;
         s3_prod_q   <= s2_prod;
         out_valid_q <= s3_valid_q;
         if (s3_valid_q) begin
            st_q[s3_chan_q] <= s3_new;
            out_chan_q      <= s3_chan_q;
            out_state_q     <= s3_new;
            out_data_q      <= sat_data;
         end
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_chan  = out_chan_q;
   assign bus.out_state = out_state_q;
   assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_ema_filter_mc.sv
// Scoreboard bench for ema_filter_mc: one stimulus stream drives an NCH=4 and an NCH=3
// instance, and an arithmetic reference model predicts every result and its arrival cycle.
module tb_ema_filter_mc;
   localparam int     DW    = 27;
   localparam int     BW    = 15;
   localparam int     CS    = 14;
   localparam int     SW    = DW + CS + 1;
   localparam longint SCALE = longint'(1) << CS;
   localparam longint DMAX  = (longint'(1) << DW) - 1;

   typedef struct {
      int     chan;
      longint state;
      longint data;
      longint want;     // pinned out_data from the test plan, -1 if none
      longint want_st;  // pinned out_state from the test plan, -1 if none
      int     edge_n;   // clock edge after which the result must appear
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid;
   logic [1:0]    in_chan;
   logic [DW-1:0] in_data;
   logic [BW-1:0] in_coeff;
   logic          in_prime;

   int     cyc = 0;
   int     n_cmp = 0;
   int     n_bad = 0;
   exp_t   q [2][$];
   longint m [2][4];
   int     nch [2] = '{4, 3};
   longint last_chan [2] = '{0, 0};
   longint last_st [2] = '{0, 0};
   longint last_data [2] = '{0, 0};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ema_filter_mc_if #(.NCH(4), .CHW(2), .DWIDTH(DW), .BWIDTH(BW), .CSHIFT(CS)) bus4 ();
   ema_filter_mc_if #(.NCH(3), .CHW(2), .DWIDTH(DW), .BWIDTH(BW), .CSHIFT(CS)) bus3 ();

   assign bus4.in_valid = in_valid;
   assign bus4.in_chan  = in_chan;
   assign bus4.in_data  = in_data;
   assign bus4.in_coeff = in_coeff;
   assign bus4.in_prime = in_prime;
   assign bus3.in_valid = in_valid;
   assign bus3.in_chan  = in_chan;
   assign bus3.in_data  = in_data;
   assign bus3.in_coeff = in_coeff;
   assign bus3.in_prime = in_prime;

   ema_filter_mc #(.NCH(4), .CHW(2), .DWIDTH(DW), .BWIDTH(BW), .CSHIFT(CS)) dut4 (
      .clk(clk), .rst_n(rst_n), .bus(bus4));
   ema_filter_mc #(.NCH(3), .CHW(2), .DWIDTH(DW), .BWIDTH(BW), .CSHIFT(CS)) dut3 (
      .clk(clk), .rst_n(rst_n), .bus(bus3));

   function automatic longint ema_next(longint st, longint x, longint coeff, bit prime);
      longint a;
      if (prime) return x * SCALE;
      a = (coeff > SCALE) ? SCALE : coeff;
      return st + a * (x - (st >>> CS));
   endfunction

   function automatic longint ema_out(longint st);
      longint r;
      r = (st + SCALE / 2) >>> CS;
      if (r < 0) return 0;
      if (r > DMAX) return DMAX;
      return r;
   endfunction

   task automatic check(string name, longint act, longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic mon_step(int d, logic ov, longint oc, longint os, longint od);
      string t;
      exp_t  e;
      t = (d == 0) ? "nch4" : "nch3";
      if (q[d].size() != 0 && q[d][0].edge_n == cyc) begin
         e = q[d].pop_front();
         check({t, " out_valid"}, longint'(ov), 1);
         check({t, " out_chan"}, oc, e.chan);
         check({t, " out_state"}, os, e.state);
         check({t, " out_data"}, od, e.data);
         if (e.want >= 0) check({t, " pinned out_data"}, od, e.want);
         if (e.want_st >= 0) check({t, " pinned out_state"}, os, e.want_st);
         last_chan[d] = e.chan;
         last_st[d]   = e.state;
         last_data[d] = e.data;
      end else begin
         check({t, " idle out_valid"}, longint'(ov), 0);
         check({t, " hold out_chan"}, oc, last_chan[d]);
         check({t, " hold out_state"}, os, last_st[d]);
         check({t, " hold out_data"}, od, last_data[d]);
      end
   endtask

   always @(negedge clk) begin
      mon_step(0, bus4.out_valid, longint'(bus4.out_chan), longint'(bus4.out_state),
               longint'(bus4.out_data));
      mon_step(1, bus3.out_valid, longint'(bus3.out_chan), longint'(bus3.out_state),
               longint'(bus3.out_data));
   end

   // Presents one slot; it is sampled on the next rising edge, after which the model
   // advances and the expected result is queued for edge+3.
   task automatic issue(bit v, int ch, longint x, longint c, bit p,
                        longint want = -1, longint want_st = -1);
      in_valid = v;
      in_chan  = 2'(ch);
      in_data  = DW'(x);
      in_coeff = BW'(c);
      in_prime = p;
      @(posedge clk);
      #1;
      if (v) begin
         for (int d = 0; d < 2; d++) begin
            if (ch < nch[d]) begin
               m[d][ch] = ema_next(m[d][ch], x, c, p);
               q[d].push_back('{chan: ch, state: m[d][ch], data: ema_out(m[d][ch]),
                                want: want, want_st: want_st, edge_n: cyc + 3});
            end
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) issue(0, 0, 0, 0, 0);
   endtask

   // One-edge reset: anything in flight is discarded and every output must read zero.
   task automatic do_reset();
      in_valid = 1'b0;
      rst_n    = 1'b0;
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         q[d].delete();
         for (int c = 0; c < 4; c++) m[d][c] = 0;
         last_chan[d] = 0;
         last_st[d]   = 0;
         last_data[d] = 0;
      end
      check("reset nch4 out_valid", longint'(bus4.out_valid), 0);
      check("reset nch4 out_chan", longint'(bus4.out_chan), 0);
      check("reset nch4 out_state", longint'(bus4.out_state), 0);
      check("reset nch4 out_data", longint'(bus4.out_data), 0);
      check("reset nch3 out_valid", longint'(bus3.out_valid), 0);
      check("reset nch3 out_data", longint'(bus3.out_data), 0);
      rst_n = 1'b1;
   endtask

   initial begin
      longint w1 [4] = '{500, 750, 875, 938};
      longint ws [4] = '{8192000, 12288000, -1, -1};
      longint x;
      int     sel;
      in_valid = 1'b0;
      in_chan  = '0;
      in_data  = '0;
      in_coeff = '0;
      in_prime = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      do_reset();

      // Convergence, one sample every 4 cycles.
      for (int i = 0; i < 4; i++) begin
         issue(1, 0, 1000, 8192, 0, w1[i], ws[i]);
         idle(3);
      end
      idle(4);
      do_reset();

      // Same channel on consecutive cycles.
      for (int i = 0; i < 4; i++) issue(1, 2, 1000, 8192, 0, w1[i], ws[i]);
      idle(4);
      do_reset();

      // Coefficient clamp, prime, full-weight return to zero.
      issue(1, 1, 777, 20000, 0, 777);
      issue(1, 1, 1234, 5, 1, 1234, 1234 * 16384);
      issue(1, 1, 0, 16384, 0, 0);
      idle(4);
      do_reset();

      // Channel independence; coeff=0 reads back the untouched channels.
      for (int c = 0; c < 4; c++) issue(1, c, 100 * (c + 1), 16384, 0, 100 * (c + 1));
      issue(1, 0, 0, 8192, 0, 50);
      for (int c = 1; c < 4; c++) issue(1, c, 0, 0, 0, 100 * (c + 1));
      idle(4);
      do_reset();

      // Saturation at full scale, and a channel the 3-channel instance must drop.
      for (int i = 0; i < 3; i++) issue(1, 0, DMAX, 16384, 0, DMAX);
      issue(1, 3, 5, 16384, 0);
      issue(1, 3, 9, 16384, 1);
      issue(1, 0, 0, 0, 0, DMAX);
      idle(4);
      do_reset();

      // Reset with three samples in flight, then a fresh start.
      issue(1, 0, 4000, 9000, 0);
      issue(1, 1, 5000, 9000, 0);
      issue(1, 2, 6000, 9000, 0);
      do_reset();
      issue(1, 0, 1000, 8192, 0, 500);
      idle(4);

      // Random traffic with frequent channel collisions and occasional resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      x = 0;
            else if (sel == 1) x = DMAX;
            else               x = longint'($urandom) & DMAX;
            issue(($urandom_range(0, 99) < 85), int'($urandom_range(0, 3)), x,
                  longint'($urandom_range(0, 20000)), ($urandom_range(0, 9) == 0));
         end
      end
      idle(6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
